column_fill_tracker: RTL and testbench

//  Upstream stage of the turn-alternation logic. Accepts the column select (1..8, 0 = none)
//  and the current player. Keeps one fill counter per column and a per-cell occupancy/owner map.

---
 rtl/column_fill_tracker.sv | 109 ++++++++++
 tb/tb_column_fill_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/column_fill_tracker.sv
// Per-column fill counters plus a cell occupancy/owner map for a drop-token board.
// Locks after the board fills or freeze is seen; only reset returns it to play.
module column_fill_tracker #(
  parameter int unsigned NUM_COLS = 8,
  parameter int unsigned NUM_ROWS = 6,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   column,
  input  logic                         player,
  input  logic                         freeze,
  output logic [NUM_COLS*CNT_W-1:0]    counters,
  output logic [NUM_COLS*NUM_ROWS-1:0] cell_occ,
  output logic [NUM_COLS*NUM_ROWS-1:0] cell_own,
  output logic                         drop_done,
  output logic                         drop_reject,
  output logic [3:0]                   last_col,
  output logic [CNT_W-1:0]             last_row,
  output logic                         board_full
);

  localparam int unsigned COL_W  = 4;
  localparam int unsigned IDX_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned CELLS  = NUM_COLS * NUM_ROWS;
  localparam int unsigned CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic {
    PLAY   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_q    [NUM_COLS];
  logic [CNT_W-1:0]     cnt_next [NUM_COLS];
  logic                 col_valid;
  logic                 accept;
  logic                 reject;
  logic                 full_next;
  logic [IDX_W-1:0]     col_idx;
  logic [CNT_W-1:0]     row_sel;
  logic [CELL_W-1:0]    cell_idx;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PLAY;
    end else begin
      state <= state_next;
    end
  end

  // Request evaluation, next counters and next state
  always_comb begin
    col_idx    = IDX_W'(column - COL_W'(1));
    col_valid  = (column != '0) && (32'(column) <= NUM_COLS);
    row_sel    = cnt_q[col_idx];
    accept     = (state == PLAY) && !freeze && col_valid && (row_sel < CNT_W'(NUM_ROWS));
    reject     = (column != '0) && !accept;
    cell_idx   = CELL_W'(col_idx) * CELL_W'(NUM_ROWS) + CELL_W'(row_sel);
    full_next  = 1'b1;
    state_next = state;
    for (int i = 0; i < int'(NUM_COLS); i++) begin
      cnt_next[i] = cnt_q[i] + CNT_W'(accept && (col_idx == IDX_W'(i)));
      if (cnt_next[i] != CNT_W'(NUM_ROWS)) begin
        full_next = 1'b0;
      end
    end
    if ((state == PLAY) && (freeze || full_next)) begin
      state_next = LOCKED;
    end
  end

  // Board contents, pulses and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_COLS); i++) begin
        cnt_q[i] <= '0;
      end
      cell_occ    <= '0;
      cell_own    <= '0;
      drop_done   <= 1'b0;
      drop_reject <= 1'b0;
      last_col    <= '0;
      last_row    <= '0;
      board_full  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_COLS); i++) begin
        cnt_q[i] <= cnt_next[i];
      end
      drop_done   <= accept;
      drop_reject <= reject;
      board_full  <= full_next;
      if (accept) begin
        cell_occ[cell_idx] <= 1'b1;
        cell_own[cell_idx] <= player;
        last_col           <= column;
        last_row           <= row_sel;
      end
    end
  end

  // Flatten counters onto the published bus
  for (genvar g = 0; g < int'(NUM_COLS); g++) begin : g_pack
    assign counters[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_column_fill_tracker.sv
// Randomised scoreboard bench for column_fill_tracker against an array-based board model.
module tb_column_fill_tracker;

  localparam int NC = 8;
  localparam int NR = 6;
  localparam int CW = 3;

  logic              clk;
  logic              reset;
  logic [3:0]        column;
  logic              player;
  logic              freeze;
  logic [NC*CW-1:0]  counters;
  logic [NC*NR-1:0]  cell_occ;
  logic [NC*NR-1:0]  cell_own;
  logic              drop_done;
  logic              drop_reject;
  logic [3:0]        last_col;
  logic [CW-1:0]     last_row;
  logic              board_full;

  column_fill_tracker #(.NUM_COLS(NC), .NUM_ROWS(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .column(column), .player(player), .freeze(freeze),
    .counters(counters), .cell_occ(cell_occ), .cell_own(cell_own),
    .drop_done(drop_done), .drop_reject(drop_reject), .last_col(last_col),
    .last_row(last_row), .board_full(board_full)
  );

  typedef struct {
    logic [NC*CW-1:0] cnt;
    logic [NC*NR-1:0] occ;
    logic [NC*NR-1:0] own;
    logic             done;
    logic             rej;
    logic [3:0]       lc;
    logic [CW-1:0]    lr;
    logic             full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference board: owner -1 means empty
  int   m_cnt [NC];
  int   m_own [NC][NR];
  bit   m_locked;
  int   m_last_col;
  int   m_last_row;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0;
      for (int r = 0; r < NR; r++) m_own[c][r] = -1;
    end
    m_locked   = 1'b0;
    m_last_col = 0;
    m_last_row = 0;
  endtask

  // Apply one request to the model and queue what the DUT must show after the edge
  task automatic model_step(input int col, input bit ply, input bit frz);
    exp_t e;
    bit   acc;
    bit   full;
    acc = !m_locked && !frz && col >= 1 && col <= NC && m_cnt[col-1] < NR;
    if (acc) begin
      m_own[col-1][m_cnt[col-1]] = ply;
      m_last_row = m_cnt[col-1];
      m_last_col = col;
      m_cnt[col-1]++;
    end
    full = 1'b1;
    for (int c = 0; c < NC; c++) if (m_cnt[c] != NR) full = 1'b0;
    if (frz || full) m_locked = 1'b1;
    e.cnt = '0;
    e.occ = '0;
    e.own = '0;
    for (int c = 0; c < NC; c++) begin
      e.cnt[c*CW +: CW] = CW'(m_cnt[c]);
      for (int r = 0; r < NR; r++) begin
        e.occ[c*NR + r] = (m_own[c][r] >= 0);
        e.own[c*NR + r] = (m_own[c][r] == 1);
      end
    end
    e.done = acc;
    e.rej  = (col != 0) && !acc;
    e.lc   = 4'(m_last_col);
    e.lr   = CW'(m_last_row);
    e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int col, input bit ply, input bit frz);
    @(negedge clk);
    column = 4'(col);
    player = ply;
    freeze = frz;
    model_step(col, ply, frz);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_counters"}, 64'(counters), 64'd0);
    check({tag, "_occ"}, 64'(cell_occ), 64'd0);
    check({tag, "_own"}, 64'(cell_own), 64'd0);
    check({tag, "_pulses"}, 64'({drop_done, drop_reject}), 64'd0);
    check({tag, "_last"}, 64'({last_col, last_row}), 64'd0);
    check({tag, "_full"}, 64'(board_full), 64'd0);
  endtask

  // Assert reset between edges, confirm immediate clear, release on a falling edge
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset  = 1'b0;
    column = '0;
    freeze = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    model_step(0, 1'b0, 1'b0);
  endtask

  function automatic int rand_col();
    int r;
    r = int'($urandom_range(0, 9));
    if (r > NC) r = int'($urandom_range(NC + 1, 15));
    return r;
  endfunction

  // Monitor: every edge the DUT presents a fresh board snapshot
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("counters", 64'(counters), 64'(mon_e.cnt));
      check("cell_occ", 64'(cell_occ), 64'(mon_e.occ));
      check("cell_own", 64'(cell_own), 64'(mon_e.own));
      check("drop_done", 64'(drop_done), 64'(mon_e.done));
      check("drop_reject", 64'(drop_reject), 64'(mon_e.rej));
      check("last_col", 64'(last_col), 64'(mon_e.lc));
      check("last_row", 64'(last_row), 64'(mon_e.lr));
      check("board_full", 64'(board_full), 64'(mon_e.full));
    end
  end

  initial begin
    reset  = 1'b0;
    column = '0;
    player = 1'b0;
    freeze = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    model_step(0, 1'b0, 1'b0);
    repeat (3) cycle(0, 1'b0, 1'b0);

    cycle(1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(2, 1'(i % 2), 1'b0);
    cycle(9, 1'b0, 1'b0);
    cycle(15, 1'b1, 1'b0);
    cycle(0, 1'b0, 1'b0);

    for (int i = 0; i < 120; i++) cycle(rand_col(), 1'($urandom_range(0, 1)), 1'b0);
    for (int c = 1; c <= NC; c++) begin
      while (m_cnt[c-1] < NR) cycle(c, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 10; i++) cycle(rand_col(), 1'($urandom_range(0, 1)), 1'b0);

    async_reset("full_reset");
    cycle(3, 1'b1, 1'b0);
    cycle(3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(rand_col(), 1'($urandom_range(0, 1)), 1'b0);
    cycle(5, 1'b0, 1'b0);

    async_reset("locked_reset");
    cycle(3, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++)
      cycle(rand_col(), 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
    cycle(0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
